instr_queue: RTL and testbench

Group-granular FIFO between instruction fetch/alignment and instruction decode. Fetch enqueues one group of `FETCH_WIDTH` aligned instructions per cycle. Decode dequeues one group per cycle through the `can_dequeue`/`dequeue` handshake. On an empty queue the head output is forced to zero, so decode sees `instrs[0].valid == 0` and inserts a bubble.

---
 rtl/instr_queue.sv | 75 +++++++
 tb/tb_instr_queue.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/instr_queue.sv
// Group-granular instruction queue between fetch/alignment and decode.
// The head group reads as all-zero when empty so decode sees a bubble.

`ifndef FETCH_WIDTH
`define FETCH_WIDTH 4
`endif

package instr_queue_pkg;
    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] instr;
    } aligned_instr_t;
endpackage

module instr_queue
    import instr_queue_pkg::*;
#(
    parameter int DEPTH       = 8,
    parameter int FETCH_WIDTH = `FETCH_WIDTH
) (
    input  logic                                i_clk,
    input  logic                                i_rst_n,
    input  logic                                i_flush,
    input  logic                                i_enqueue,
    input  aligned_instr_t [0:FETCH_WIDTH-1]    i_instrs,
    output logic                                o_can_enqueue,
    output logic                                o_can_dequeue,
    input  logic                                i_dequeue,
    output aligned_instr_t [0:FETCH_WIDTH-1]    o_instrs,
    output logic [$clog2(DEPTH):0]              o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] FULL_COUNT = PW'(DEPTH);

    aligned_instr_t [0:FETCH_WIDTH-1] mem [DEPTH];

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          enq_fire;
    logic          deq_fire;

    // Handshakes come only from the registered pointers; the extra wrap
    // bit lets the pointer difference distinguish full from empty.
    always_comb begin
        o_count       = wr_ptr - rd_ptr;
        o_can_enqueue = (o_count != FULL_COUNT);
        o_can_dequeue = (o_count != '0);
        enq_fire      = i_rst_n & i_enqueue & o_can_enqueue & ~i_flush;
        deq_fire      = i_rst_n & i_dequeue & o_can_dequeue & ~i_flush;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n || i_flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (enq_fire) wr_ptr <= wr_ptr + 1'b1;
            if (deq_fire) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage is never cleared; the empty mask keeps stale groups hidden.
    always_ff @(posedge i_clk) begin
        if (enq_fire) mem[wr_ptr[AW-1:0]] <= i_instrs;
    end

    always_comb begin
        o_instrs = '0;
        if (o_can_dequeue) o_instrs = mem[rd_ptr[AW-1:0]];
    end

endmodule

// File: tb/tb_instr_queue.sv
// Directed bench for instr_queue with a queue-based scoreboard of groups.
// Outputs are checked mid-cycle, before the edge that consumes the inputs.

module tb_instr_queue;

    localparam int DEPTH = 8;
    localparam int FW    = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    typedef instr_queue_pkg::aligned_instr_t [0:FW-1] group_t;
    localparam int GW = $bits(group_t);

    logic          i_clk = 1'b0;
    logic          i_rst_n = 1'b0;
    logic          i_flush = 1'b0;
    logic          i_enqueue = 1'b0;
    logic          i_dequeue = 1'b0;
    group_t        i_instrs = '0;
    group_t        o_instrs;
    logic          o_can_enqueue;
    logic          o_can_dequeue;
    logic [CW-1:0] o_count;

    int     compared = 0;
    int     mismatched = 0;
    group_t sb_q[$];
    logic [31:0] next_pc = 32'h100;

    instr_queue #(.DEPTH(DEPTH), .FETCH_WIDTH(FW)) dut (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .i_flush       (i_flush),
        .i_enqueue     (i_enqueue),
        .i_instrs      (i_instrs),
        .o_can_enqueue (o_can_enqueue),
        .o_can_dequeue (o_can_dequeue),
        .i_dequeue     (i_dequeue),
        .o_instrs      (o_instrs),
        .o_count       (o_count)
    );

    always #5 i_clk = ~i_clk;

    function automatic group_t make_group(input logic [31:0] pc);
        group_t g;
        for (int k = 0; k < FW; k++) begin
            g[k].valid = 1'b1;
            g[k].pc    = pc + 32'(4 * k);
            g[k].instr = {pc[15:0], 16'(k)} ^ 32'h5A5A_0000;
        end
        return g;
    endfunction

    task automatic checkOutput(input string tag, input logic [GW-1:0] observed,
                               input logic [GW-1:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // One cycle: drive at negedge, check pre-edge state, advance the model.
    task automatic applyStimulus(input logic enq, input logic deq, input logic flush);
        group_t g;
        bit     enq_ok;
        bit     deq_ok;
        group_t head_exp;
        @(negedge i_clk);
        g         = make_group(next_pc);
        i_enqueue = enq;
        i_dequeue = deq;
        i_flush   = flush;
        i_instrs  = g;
        #1;
        head_exp = (sb_q.size() > 0) ? sb_q[0] : '0;
        checkOutput("count",       GW'(o_count),       GW'(sb_q.size()));
        checkOutput("can_enqueue", GW'(o_can_enqueue), GW'(sb_q.size() != DEPTH));
        checkOutput("can_dequeue", GW'(o_can_dequeue), GW'(sb_q.size() != 0));
        checkOutput("head",        o_instrs,           head_exp);
        enq_ok = enq && !flush && (sb_q.size() < DEPTH);
        deq_ok = deq && !flush && (sb_q.size() > 0);
        if (flush) begin
            sb_q.delete();
        end else begin
            if (deq_ok) void'(sb_q.pop_front());
            if (enq_ok) sb_q.push_back(g);
        end
        if (enq) next_pc = next_pc + 32'h8;
    endtask

    initial begin
        $display("[TB] start");
        i_enqueue = 1'b1;
        i_instrs  = make_group(32'hDEAD_0000);
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        i_rst_n   = 1'b1;
        i_enqueue = 1'b0;
        #1;
        checkOutput("reset_count",  GW'(o_count),         GW'(0));
        checkOutput("reset_canenq", GW'(o_can_enqueue),   GW'(1));
        checkOutput("reset_candeq", GW'(o_can_dequeue),   GW'(0));
        checkOutput("reset_valid0", GW'(o_instrs[0].valid), GW'(0));

        // Fill to full plus one ignored group, then drain in order.
        next_pc = 32'h100;
        repeat (9) applyStimulus(1'b1, 1'b0, 1'b0);
        repeat (8) applyStimulus(1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);

        // Streaming at count 3 across several pointer wraps.
        next_pc = 32'h300;
        repeat (3) applyStimulus(1'b1, 1'b0, 1'b0);
        repeat (40) applyStimulus(1'b1, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);

        // Full with simultaneous enqueue and dequeue.
        repeat (5) applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        repeat (7) applyStimulus(1'b0, 1'b1, 1'b0);

        // Empty corners: lone dequeue, then enqueue with dequeue.
        applyStimulus(1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        next_pc = 32'h400;
        applyStimulus(1'b1, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0);

        // Flush at count 5 with enqueue/dequeue, then refill.
        next_pc = 32'h500;
        repeat (5) applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0);
        next_pc = 32'h200;
        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
